riscv32ima_mem_wb: RTL and testbench
====================================

// Module: riscv32ima_mem_wb
// PURPOSE
// - Memory-access/writeback stage, directly downstream of the ALU stage.
// - Consumes ALU results (alu_* valid/ready bundle).
// - Performs LOAD/STORE on a req/gnt/rvalid data-memory port.
// - Drives the registered wback_reg_* bus back to the register file and the ALU bypass.
// - One instruction is in flight at a time; ALU-only ops retire in 1 cycle.
// PARAMETERS
// ADDR_WIDTH      32  data-memory byte address width
// REG_ADDR_WIDTH  5   register index width
// REG_DATA_WIDTH  32  register/data width; memory bus is 32 bit, 4 byte lanes
// OPCODE_WIDTH    7   opcode width
// FUNC3_WIDTH     3   func3 width
// PORTS
// clk              in   1   clock
// nrst             in   1   reset, synchronous, active-low
// alu_valid        in   1   ALU result valid
// alu_ready        out  1   stage can accept; equals (state==IDLE)
// alu_opcode       in   7   RV opcode of retiring instruction
// alu_func3_opcode in   3   func3 (load/store size and sign)
// alu_dst_addr     in   5   rd
// alu_src_addr     in   5   rs2 index (store); unused internally, kept for trace
// alu_mem_addr     in   32  effective byte address (LOAD/STORE)
// alu_data         in   32  rd result, or store data for STORE
// dmem_req         out  1   memory request, held until dmem_gnt
// dmem_we          out  1   1=store, 0=load
// dmem_addr        out  32  word-aligned address {alu_mem_addr[31:2],2'b00}
// dmem_be          out  4   byte enables (stores); 4'b1111 on loads
// dmem_wdata       out  32  lane-replicated store data
// dmem_gnt         in   1   request accepted
// dmem_rvalid      in   1   load data valid, >=1 cycle after gnt
// dmem_rdata       in   32  load data word
// mem_fault        out  1   1-cycle pulse: misaligned address or illegal func3
// wback_reg_wen    out  1   1-cycle writeback pulse; never asserted for rd==0
// wback_reg_addr   out  5   writeback rd
// wback_reg_data   out  32  writeback data
// BEHAVIOUR
// - Reset values: state IDLE; dmem_req=0, dmem_we=0, mem_fault=0, wback_reg_wen=0.
//   All other outputs are 0. A reset mid-access drops dmem_req at the next edge.
//   A late dmem_rvalid after reset is ignored.
// - Accept on alu_valid & alu_ready (cycle N); the instruction is latched.
// - rd-writing ops OP, OP_IMM, LUI, AUIPC, JAL, JALR:
//   - wback_reg_wen=(rd!=0) at N+1, data=alu_data; state stays IDLE.
//   - Back-to-back throughput is 1 per cycle.
// - BRANCH, MISC_MEM, SYSTEM and other opcodes: consumed, no side effect.
// - LOAD/STORE alignment check at accept:
//   - H requires addr[0]==0; W requires addr[1:0]==0.
//   - Legal load func3 = 000/001/010/100/101; legal store func3 = 000/001/010.
//   - Violation: mem_fault=1 at N+1, no dmem_req, no writeback, state stays IDLE.
// - FSM IDLE->REQ: dmem_req=1 from N+1, held with stable addr/we/be/wdata until dmem_gnt.
// - REQ & gnt & STORE -> IDLE. Store retires silently.
// - REQ & gnt & LOAD -> RESP. dmem_rvalid is sampled only in RESP.
// - RESP & rvalid -> IDLE. Writeback pulse next cycle:
//   - Select lane by addr[1:0].
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
// - Minimum load latency is accept N -> wback N+3 (gnt at N+1, rvalid at N+2).
// - Store lanes:
//   - SB: be=4'b0001<<a[1:0], wdata={4{d[7:0]}}.
//   - SH: be=a[1]?1100:0011, wdata={2{d[15:0]}}.
//   - SW: be=1111.
// - alu_ready is low in REQ/RESP. The ALU stalls; no input is consumed.
// - wback_reg_wen is never high two cycles for one instruction.
// STRUCTURE
// - riscv32ima_pkg holds: opcode constants (LOAD, STORE, OP, ...), load/store func3
//   encodings, and typedef enum {IDLE,REQ,RESP} mem_state_t.
// - Sub-module riscv32ima_lsu_align (combinational) computes be, wdata, misalign,
//   and load extract/extend.
// TESTING
// 1. OP, rd=5, data=0x1234, then back-to-back OP rd=6 -> wen pulses N+1 and N+2;
//    alu_ready stays 1.
// 2. LB addr=0x1003, rdata=0x80FF_FF00, gnt+1, rvalid+2 -> wback 0xFFFF_FF80 at N+3.
//    LBU on the same data -> 0x0000_0080.
// 3. SH addr=0x2002, data=0xABCD_5678 -> dmem_be=1100, wdata=0x5678_5678.
//    gnt delayed 3 cycles: req and fields stable, alu_ready=0; no wback.
// 4. LW addr=0x0006 -> mem_fault pulse at N+1, no dmem_req, no wback.
//    Next valid op is accepted at N+1.
// 5. LUI rd=0, data=0x1000 -> wback_reg_wen stays 0.
// 6. nrst low while in RESP, then rvalid -> no wback.
//    dmem_req=0 and alu_ready=1 after reset.

Source files
------------

// File: rtl/riscv32ima_pkg.sv
// Shared opcode and func3 encodings, plus the memory-stage FSM state type.
package riscv32ima_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    function automatic logic writes_rd(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
               (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/riscv32ima_lsu_align.sv
// Byte-lane logic for the data-memory port: store enables/replication,
// alignment and func3 legality, and load lane extract with sign/zero extension.
module riscv32ima_lsu_align
    import riscv32ima_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_is_store,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_fault,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_be        = 4'b1111;
        o_wdata     = i_wdata;
        o_fault     = 1'b0;
        o_load_data = i_rdata;
        if (i_is_store) begin
            case (i_func3)
                F3_B: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                F3_H: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_wdata[15:0]}};
                    o_fault = i_addr_lo[0];
                end
                F3_W:    o_fault = |i_addr_lo;
                default: o_fault = 1'b1;
            endcase
        end else begin
            // Loads always fetch the full word; the lane is picked on return.
            case (i_func3)
                F3_B:  o_load_data = {{24{w_byte[7]}}, w_byte};
                F3_BU: o_load_data = {24'd0, w_byte};
                F3_H: begin
                    o_load_data = {{16{w_half[15]}}, w_half};
                    o_fault     = i_addr_lo[0];
                end
                F3_HU: begin
                    o_load_data = {16'd0, w_half};
                    o_fault     = i_addr_lo[0];
                end
                F3_W:    o_fault = |i_addr_lo;
                default: o_fault = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/riscv32ima_mem_wb.sv
// Memory-access / writeback stage: retires ALU ops in one cycle, runs one
// load or store at a time over req/gnt/rvalid, and drives the registered wback bus.
module riscv32ima_mem_wb
    import riscv32ima_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32,
    parameter int OPCODE_WIDTH   = 7,
    parameter int FUNC3_WIDTH    = 3
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [OPCODE_WIDTH-1:0]   alu_opcode,
    input  logic [FUNC3_WIDTH-1:0]    alu_func3_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] alu_dst_addr,
    input  logic [REG_ADDR_WIDTH-1:0] alu_src_addr,
    input  logic [ADDR_WIDTH-1:0]     alu_mem_addr,
    input  logic [REG_DATA_WIDTH-1:0] alu_data,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [ADDR_WIDTH-1:0]     dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [31:0]               dmem_wdata,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [31:0]               dmem_rdata,
    output logic                      mem_fault,
    output logic                      wback_reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] wback_reg_addr,
    output logic [REG_DATA_WIDTH-1:0] wback_reg_data,
    output mem_state_t                dbg_state,
    output logic [REG_ADDR_WIDTH-1:0] dbg_src_addr
);

    // Handshake: an instruction is consumed on a cycle where alu_valid and
    // alu_ready are both high; alu_ready is high only in IDLE, and
    // dmem_req stays high with stable fields until the cycle dmem_gnt is seen.
    mem_state_t                r_state, w_state_n;
    logic                      r_we;
    logic [FUNC3_WIDTH-1:0]    r_func3;
    logic [REG_ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [3:0]                r_be;
    logic [31:0]               r_wdata;
    logic [REG_ADDR_WIDTH-1:0] r_src_addr;
    logic                      r_wen, w_wen_n;
    logic [REG_ADDR_WIDTH-1:0] r_wb_addr, w_wb_addr_n;
    logic [REG_DATA_WIDTH-1:0] r_wb_data, w_wb_data_n;
    logic                      r_fault, w_fault_n;

    logic                      w_accept, w_is_load, w_is_store, w_mem_op;
    logic [FUNC3_WIDTH-1:0]    w_sel_func3;
    logic [1:0]                w_sel_addr_lo;
    logic                      w_sel_store;
    logic [3:0]                w_be;
    logic [31:0]               w_wdata, w_load_data;
    logic                      w_fault;

    assign w_accept   = alu_valid && (r_state == IDLE);
    assign w_is_load  = (alu_opcode == OPC_LOAD);
    assign w_is_store = (alu_opcode == OPC_STORE);
    assign w_mem_op   = w_is_load || w_is_store;

    // In IDLE the lane logic checks the incoming op; otherwise it serves the latched one.
    assign w_sel_func3   = (r_state == IDLE) ? alu_func3_opcode : r_func3;
    assign w_sel_addr_lo = (r_state == IDLE) ? alu_mem_addr[1:0] : r_addr[1:0];
    assign w_sel_store   = (r_state == IDLE) ? w_is_store : r_we;

    riscv32ima_lsu_align u_align (
        .i_func3     (w_sel_func3),
        .i_addr_lo   (w_sel_addr_lo),
        .i_is_store  (w_sel_store),
        .i_wdata     (alu_data),
        .i_rdata     (dmem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_fault     (w_fault),
        .o_load_data (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_wen     <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_wen     <= w_wen_n;
            r_wb_addr <= w_wb_addr_n;
            r_wb_data <= w_wb_data_n;
            r_fault   <= w_fault_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_wen_n     = 1'b0;
        w_wb_addr_n = r_wb_addr;
        w_wb_data_n = r_wb_data;
        w_fault_n   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_mem_op) begin
                        if (w_fault) w_fault_n = 1'b1;
                        else         w_state_n = REQ;
                    end else if (writes_rd(alu_opcode)) begin
                        w_wen_n     = (alu_dst_addr != '0);
                        w_wb_addr_n = alu_dst_addr;
                        w_wb_data_n = alu_data;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) w_state_n = r_we ? IDLE : RESP;
            end
            RESP: begin
                if (dmem_rvalid) begin
                    w_state_n   = IDLE;
                    w_wen_n     = (r_dst != '0);
                    w_wb_addr_n = r_dst;
                    w_wb_data_n = w_load_data;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_we       <= 1'b0;
            r_func3    <= '0;
            r_dst      <= '0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_src_addr <= '0;
        end else if (w_accept) begin
            r_src_addr <= alu_src_addr;
            if (w_mem_op && !w_fault) begin
                r_we    <= w_is_store;
                r_func3 <= alu_func3_opcode;
                r_dst   <= alu_dst_addr;
                r_addr  <= alu_mem_addr;
                r_be    <= w_is_store ? w_be : 4'b1111;
                r_wdata <= w_is_store ? w_wdata : 32'd0;
            end
        end
    end

    assign alu_ready      = (r_state == IDLE);
    assign dmem_req       = (r_state == REQ);
    assign dmem_we        = r_we;
    assign dmem_addr      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_be        = r_be;
    assign dmem_wdata     = r_wdata;
    assign mem_fault      = r_fault;
    assign wback_reg_wen  = r_wen;
    assign wback_reg_addr = r_wb_addr;
    assign wback_reg_data = r_wb_data;
    assign dbg_state      = r_state;
    assign dbg_src_addr   = r_src_addr;

endmodule

// File: tb/tb_riscv32ima_mem_wb.sv
// Directed bench for riscv32ima_mem_wb: stimulus pushes expected writebacks,
// a negedge monitor pops and compares every wback pulse.
module tb_riscv32ima_mem_wb;
  import riscv32ima_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        alu_valid, alu_ready;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_func3_opcode;
  logic [4:0]  alu_dst_addr, alu_src_addr;
  logic [31:0] alu_mem_addr, alu_data;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_fault, wback_reg_wen;
  logic [4:0]  wback_reg_addr, dbg_src_addr;
  logic [31:0] wback_reg_data;
  mem_state_t  dbg_state;

  always #5 clk = ~clk;

  riscv32ima_mem_wb dut (
    .clk(clk), .nrst(nrst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_opcode(alu_opcode),
    .alu_func3_opcode(alu_func3_opcode), .alu_dst_addr(alu_dst_addr),
    .alu_src_addr(alu_src_addr), .alu_mem_addr(alu_mem_addr), .alu_data(alu_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .mem_fault(mem_fault), .wback_reg_wen(wback_reg_wen),
    .wback_reg_addr(wback_reg_addr), .wback_reg_data(wback_reg_data),
    .dbg_state(dbg_state), .dbg_src_addr(dbg_src_addr)
  );

  int tests = 0;
  int fails = 0;
  int exp_faults = 0;
  int seen_faults = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mem_fault === 1'b1) seen_faults++;
    if (wback_reg_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%08h expected no writeback",
                 wback_reg_addr, wback_reg_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_addr", {27'd0, wback_reg_addr}, {27'd0, mon_e[36:32]});
        chk("wb_data", wback_reg_data, mon_e[31:0]);
      end
    end
  end

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] data);
    bit got = 0;
    alu_valid = 1'b1;
    alu_opcode = opc;
    alu_func3_opcode = f3;
    alu_dst_addr = rd;
    alu_src_addr = 5'd3;
    alu_mem_addr = addr;
    alu_data = data;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (alu_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got alu_ready=0 for 20 cycles expected 1");
    end
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    exp_q.push_back({rd, exp});
    issue(OPC_LOAD, f3, rd, addr, 32'h0);
    chk("ld_req", {31'd0, dmem_req}, 32'd1);
    chk("ld_we", {31'd0, dmem_we}, 32'd0);
    chk("ld_addr", dmem_addr, {addr[31:2], 2'b00});
    chk("ld_be", {28'd0, dmem_be}, 32'hF);
    chk("ld_ready", {31'd0, alu_ready}, 32'd0);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    chk("ld_resp_state", 32'(dbg_state), 32'(RESP));
    dmem_rvalid = 1'b1;
    dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("ld_wen_n3", {31'd0, wback_reg_wen}, {31'd0, rd != 5'd0});
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic [31:0] wdata, input int stall);
    issue(OPC_STORE, f3, 5'd0, addr, data);
    chk("st_addr", dmem_addr, {addr[31:2], 2'b00});
    chk("st_we", {31'd0, dmem_we}, 32'd1);
    for (int s = 0; s <= stall; s++) begin
      chk("st_req", {31'd0, dmem_req}, 32'd1);
      chk("st_be", {28'd0, dmem_be}, {28'd0, be});
      chk("st_wdata", dmem_wdata, wdata);
      chk("st_ready", {31'd0, alu_ready}, 32'd0);
      if (s == stall) dmem_gnt = 1'b1;
      @(posedge clk); #1;
    end
    dmem_gnt = 1'b0;
    chk("st_done_req", {31'd0, dmem_req}, 32'd0);
    chk("st_done_ready", {31'd0, alu_ready}, 32'd1);
    chk("st_no_wb", {31'd0, wback_reg_wen}, 32'd0);
  endtask

  task automatic do_fault(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr);
    exp_faults++;
    issue(opc, f3, 5'd8, addr, 32'h55);
    chk("flt_pulse", {31'd0, mem_fault}, 32'd1);
    chk("flt_no_req", {31'd0, dmem_req}, 32'd0);
    chk("flt_ready", {31'd0, alu_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    alu_valid = 1'b0; alu_opcode = '0; alu_func3_opcode = '0; alu_dst_addr = '0;
    alu_src_addr = '0; alu_mem_addr = '0; alu_data = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_fault", {31'd0, mem_fault}, 32'd0);
    chk("rst_wen", {31'd0, wback_reg_wen}, 32'd0);
    chk("rst_wb_data", wback_reg_data, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_ready", {31'd0, alu_ready}, 32'd1);
    nrst = 1'b1;

    // back-to-back ALU ops
    exp_q.push_back({5'd5, 32'h0000_1234});
    exp_q.push_back({5'd6, 32'h0000_5678});
    issue(OPC_OP, 3'b000, 5'd5, 32'h0, 32'h0000_1234);
    chk("op_wen_n1", {31'd0, wback_reg_wen}, 32'd1);
    chk("op_ready_b2b", {31'd0, alu_ready}, 32'd1);
    issue(OPC_OP_IMM, 3'b000, 5'd6, 32'h0, 32'h0000_5678);
    chk("op_wen_n2", {31'd0, wback_reg_wen}, 32'd1);
    chk("op_wb_rd6", {27'd0, wback_reg_addr}, 32'd6);
    @(posedge clk); #1;
    chk("op_single_pulse", {31'd0, wback_reg_wen}, 32'd0);

    // loads
    do_load(F3_B,  5'd10, 32'h0000_1003, 32'h80FF_FF00, 32'hFFFF_FF80);
    do_load(F3_BU, 5'd11, 32'h0000_1003, 32'h80FF_FF00, 32'h0000_0080);
    do_load(F3_H,  5'd12, 32'h0000_1002, 32'h80FF_FF00, 32'hFFFF_80FF);
    do_load(F3_HU, 5'd13, 32'h0000_1002, 32'h80FF_FF00, 32'h0000_80FF);
    do_load(F3_W,  5'd14, 32'h0000_1000, 32'h1234_5678, 32'h1234_5678);

    // stores
    do_store(F3_H, 32'h0000_2002, 32'hABCD_5678, 4'b1100, 32'h5678_5678, 3);
    do_store(F3_B, 32'h0000_3001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5, 0);
    do_store(F3_W, 32'h0000_3004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1);

    // faults, next op accepted at N+1
    do_fault(OPC_LOAD, F3_W, 32'h0000_0006);
    exp_q.push_back({5'd7, 32'h0000_0077});
    issue(OPC_OP, 3'b000, 5'd7, 32'h0, 32'h0000_0077);
    chk("flt_next_wen", {31'd0, wback_reg_wen}, 32'd1);
    chk("flt_cleared", {31'd0, mem_fault}, 32'd0);
    do_fault(OPC_STORE, F3_H, 32'h0000_2001);
    do_fault(OPC_STORE, 3'b100, 32'h0000_3000);
    do_fault(OPC_LOAD, 3'b011, 32'h0000_0000);

    // rd==0 and no-effect opcodes
    issue(OPC_LUI, 3'b000, 5'd0, 32'h0, 32'h0000_1000);
    chk("lui_x0_wen", {31'd0, wback_reg_wen}, 32'd0);
    issue(OPC_BRANCH, 3'b000, 5'd4, 32'h0000_0100, 32'h1);
    chk("br_wen", {31'd0, wback_reg_wen}, 32'd0);
    chk("br_req", {31'd0, dmem_req}, 32'd0);

    // reset during RESP, then late rvalid
    issue(OPC_LOAD, F3_W, 5'd9, 32'h0000_0010, 32'h0);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    chk("rr_in_resp", 32'(dbg_state), 32'(RESP));
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    chk("rr_req", {31'd0, dmem_req}, 32'd0);
    chk("rr_ready", {31'd0, alu_ready}, 32'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("rr_no_wb", {31'd0, wback_reg_wen}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("wb_queue_empty", exp_q.size(), 32'd0);
    chk("fault_count", seen_faults, exp_faults);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
